mem_lsu: RTL

//  MEM-stage load/store unit. Drives the data-memory bus with a req/gnt/rvalid handshake.

---
 rtl/mem_lsu_pkg.sv | 46 ++++
 rtl/mem_lsu_if.sv | 21 ++
 rtl/mem_lsu_align.sv | 49 ++++
 rtl/mem_lsu.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared types, size codes and lane helpers for the MEM-stage load/store unit.
package lsu_pkg;

  localparam int unsigned LSU_WIDTH = 32;

  // Access FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  // funct3 encodings of the load/store size field
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Internal access size codes (sign handling happens later in WB)
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Collapse funct3 to an access size; unknown encodings behave as a word.
  function automatic logic [1:0] size_f(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_f = SZ_B;
      F3_H, F3_HU: size_f = SZ_H;
      F3_W:        size_f = SZ_W;
      default:     size_f = SZ_W;
    endcase
  endfunction

  // Byte enables for a store of the given size at byte offset a.
  function automatic logic [3:0] wstrb_f(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_B:    wstrb_f = 4'b0001 << a;
      SZ_H:    wstrb_f = 4'b0011 << a;
      SZ_W:    wstrb_f = 4'b1111;
      default: wstrb_f = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory bus: request side driven by the LSU, grant/response by memory.
interface mem_lsu_if #(parameter int unsigned Width = 32);
  logic             req;
  logic             we;
  logic [Width-1:0] addr;
  logic [Width-1:0] wdata;
  logic [3:0]       wstrb;
  logic             gnt;
  logic             rvalid;
  logic [Width-1:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Lane alignment: store replication/strobes, alignment check, load right-shift.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           st_alo_i,
  input  logic [LSU_WIDTH-1:0] st_data_i,
  input  logic [1:0]           ld_alo_i,
  input  logic [LSU_WIDTH-1:0] ld_rdata_i,
  output logic [LSU_WIDTH-1:0] st_wdata_o,
  output logic [3:0]           st_wstrb_o,
  output logic                 aligned_o,
  output logic [LSU_WIDTH-1:0] ld_data_o
);

  logic [1:0] size_s;

  // Store-side lane replication, byte enables and natural-alignment check
  always_comb begin
    size_s     = size_f(funct3_i);
    st_wdata_o = st_data_i;
    aligned_o  = 1'b1;
    case (size_s)
      SZ_B: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        aligned_o  = 1'b1;
      end
      SZ_H: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        aligned_o  = (st_alo_i[0] == 1'b0);
      end
      SZ_W: begin
        st_wdata_o = st_data_i;
        aligned_o  = (st_alo_i == 2'b00);
      end
      default: begin
        st_wdata_o = st_data_i;
        aligned_o  = (st_alo_i == 2'b00);
      end
    endcase
    st_wstrb_o = wstrb_f(size_s, st_alo_i);
  end

  // Load-side shift so the addressed byte lands in bits [7:0]
  always_comb begin
    ld_data_o = ld_rdata_i >> {ld_alo_i, 3'b000};
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one bus access per instruction and
// stalls the pipeline until it finishes; returns the lane-aligned load word.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned Width = LSU_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_MEM,
  input  logic             MemRd_MEM,
  input  logic             MemWr_MEM,
  input  logic [2:0]       funct3_MEM,
  input  logic [Width-1:0] alu_MEM,
  input  logic [Width-1:0] dataW_MEM,
  output logic [Width-1:0] dataR,
  output logic             done_o,
  output logic             stall_o,
  output logic             misalign_o,
  mem_lsu_if.master        bus
);

  state_e state_q, state_d;

  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [Width-1:0] addr_q, addr_d;
  logic [Width-1:0] wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [1:0]       alo_q, alo_d;
  logic [Width-1:0] data_r_q, data_r_d;
  logic             done_q, done_d;
  logic             misalign_q, misalign_d;

  logic             access_s;
  logic             aligned_s;
  logic             start_s;
  logic [Width-1:0] st_wdata_s;
  logic [3:0]       st_wstrb_s;
  logic [Width-1:0] ld_data_s;

  lsu_align u_align (
    .funct3_i   (funct3_MEM),
    .st_alo_i   (alu_MEM[1:0]),
    .st_data_i  (dataW_MEM),
    .ld_alo_i   (alo_q),
    .ld_rdata_i (bus.rdata),
    .st_wdata_o (st_wdata_s),
    .st_wstrb_o (st_wstrb_s),
    .aligned_o  (aligned_s),
    .ld_data_o  (ld_data_s)
  );

  // Start only from IDLE, so an instruction still held during DONE is not reissued
  always_comb begin
    access_s = valid_MEM & (MemRd_MEM | MemWr_MEM);
    start_s  = access_s & aligned_s & (state_q == IDLE);
    stall_o  = start_s | (state_q == REQ) | (state_q == RESP);
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; gnt/rvalid only matter in their own states
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.gnt) begin
          state_d = we_q ? DONE : RESP;
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        if (bus.rvalid) begin
          state_d = DONE;
        end else begin
          state_d = RESP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output logic: next values of the registered bus fields and results
  always_comb begin
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    alo_d      = alo_q;
    data_r_d   = data_r_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          req_d   = 1'b1;
          we_d    = MemWr_MEM;
          addr_d  = {alu_MEM[Width-1:2], 2'b00};
          wdata_d = st_wdata_s;
          wstrb_d = st_wstrb_s;
          alo_d   = alu_MEM[1:0];
        end else begin
          req_d = 1'b0;
        end
        if (access_s && !aligned_s) begin
          misalign_d = 1'b1;
        end else begin
          misalign_d = 1'b0;
        end
      end
      REQ: begin
        if (bus.gnt) begin
          req_d  = 1'b0;
          done_d = we_q;
        end else begin
          req_d  = 1'b1;
          done_d = 1'b0;
        end
      end
      RESP: begin
        if (bus.rvalid) begin
          data_r_d = ld_data_s;
          done_d   = 1'b1;
        end else begin
          data_r_d = data_r_q;
          done_d   = 1'b0;
        end
      end
      DONE: begin
        req_d = 1'b0;
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  // Registered bus fields, load result and status pulses
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= 4'b0000;
      alo_q      <= 2'b00;
      data_r_q   <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      alo_q      <= alo_d;
      data_r_q   <= data_r_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.req    = req_q;
  assign bus.we     = we_q;
  assign bus.addr   = addr_q;
  assign bus.wdata  = wdata_q;
  assign bus.wstrb  = wstrb_q;
  assign dataR      = data_r_q;
  assign done_o     = done_q;
  assign misalign_o = misalign_q;

endmodule
